ffd_posneg: RTL and testbench



---
 rtl/ffd_pkg.sv | 20 ++
 rtl/ffd_posneg_if.sv | 19 +
 rtl/ffd_edge_reg.sv | 34 +++
 rtl/ffd_posneg.sv | 64 ++++++
 tb/tb_ffd_posneg.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/ffd_pkg.sv
// rtl/ffd_pkg.sv - shared edge-mode encodings and defaults for the ffd_posneg register
package ffd_pkg;

  localparam int DEFAULT_LEN = 8;

  localparam int EDGE_POS  = 0;
  localparam int EDGE_NEG  = 1;
  localparam int EDGE_BOTH = 2;

  typedef enum logic [1:0] {
    EM_POS  = 2'd0,
    EM_NEG  = 2'd1,
    EM_BOTH = 2'd2
  } edge_mode_e;

  function automatic bit edge_mode_valid(input int mode);
    return (mode == EDGE_POS) || (mode == EDGE_NEG) || (mode == EDGE_BOTH);
  endfunction

endpackage

// File: rtl/ffd_posneg_if.sv
// rtl/ffd_posneg_if.sv - data in/out bundle between a producer and the ffd_posneg register
interface ffd_posneg_if #(
  parameter int LEN = 8
);

  logic [LEN-1:0] datain;
  logic [LEN-1:0] dataout;

  modport master (
    output datain,
    input  dataout
  );

  modport slave (
    input  datain,
    output dataout
  );

endinterface

// File: rtl/ffd_edge_reg.sv
// rtl/ffd_edge_reg.sv - single-edge LEN-bit register, sync active-low clear, XOR mix term
// The stored value is (clr ? d : 0) ^ mix; mix is zero for a plain register.
module ffd_edge_reg #(
  parameter int LEN = 8,
  parameter bit NEG = 1'b0
) (
  input  logic           clk_i,
  input  logic           clr_ni,
  input  logic [LEN-1:0] d_i,
  input  logic [LEN-1:0] mix_i,
  output logic [LEN-1:0] q_o
);

  logic [LEN-1:0] q_d;
  logic [LEN-1:0] q_q;

  // Clearing stores the mix term so that an XOR pair reads back zero.
  always_comb begin
    q_d = (clr_ni ? d_i : {LEN{1'b0}}) ^ mix_i;
  end

  if (NEG) begin : g_neg
    always_ff @(negedge clk_i) begin
      q_q <= q_d;
    end
  end else begin : g_pos
    always_ff @(posedge clk_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/ffd_posneg.sv
// rtl/ffd_posneg.sv - LEN-bit D register capturing on rising, falling or both clock edges
module ffd_posneg
  import ffd_pkg::*;
#(
  parameter int LEN       = DEFAULT_LEN,
  parameter int EDGE_MODE = EDGE_NEG
) (
  input  logic         clk,
  input  logic         clr,
  ffd_posneg_if.slave  bus
);

  logic [LEN-1:0] zero_mix;
  assign zero_mix = {LEN{1'b0}};

  if (EDGE_MODE == EDGE_POS || EDGE_MODE == EDGE_NEG) begin : g_single
    logic [LEN-1:0] q;

    ffd_edge_reg #(
      .LEN (LEN),
      .NEG (EDGE_MODE == EDGE_NEG)
    ) u_reg (
      .clk_i  (clk),
      .clr_ni (clr),
      .d_i    (bus.datain),
      .mix_i  (zero_mix),
      .q_o    (q)
    );

    assign bus.dataout = q;
  end else if (EDGE_MODE == EDGE_BOTH) begin : g_dual
    // p ^ n always equals the value sampled at the latest edge of either polarity.
    logic [LEN-1:0] p_q;
    logic [LEN-1:0] n_q;

    ffd_edge_reg #(
      .LEN (LEN),
      .NEG (1'b0)
    ) u_pos (
      .clk_i  (clk),
      .clr_ni (clr),
      .d_i    (bus.datain),
      .mix_i  (n_q),
      .q_o    (p_q)
    );

    ffd_edge_reg #(
      .LEN (LEN),
      .NEG (1'b1)
    ) u_neg (
      .clk_i  (clk),
      .clr_ni (clr),
      .d_i    (bus.datain),
      .mix_i  (p_q),
      .q_o    (n_q)
    );

    assign bus.dataout = p_q ^ n_q;
  end else begin : g_bad
    $error("ffd_posneg: EDGE_MODE must be 0, 1 or 2");
    assign bus.dataout = zero_mix;
  end

endmodule

// File: tb/tb_ffd_posneg.sv
// tb/tb_ffd_posneg.sv - directed checks of rising, falling and dual-edge ffd_posneg instances
module tb_ffd_posneg;

  logic       clk;
  logic       clr;
  logic [7:0] din;
  int         total;
  int         bad;
  logic [7:0] prev_m1;

  ffd_posneg_if #(.LEN(8)) bus0 ();
  ffd_posneg_if #(.LEN(8)) bus1 ();
  ffd_posneg_if #(.LEN(8)) bus2 ();

  assign bus0.datain = din;
  assign bus1.datain = din;
  assign bus2.datain = din;

  ffd_posneg #(.LEN(8), .EDGE_MODE(0)) dut0 (.clk(clk), .clr(clr), .bus(bus0));
  ffd_posneg #(.LEN(8), .EDGE_MODE(1)) dut1 (.clk(clk), .clr(clr), .bus(bus1));
  ffd_posneg #(.LEN(8), .EDGE_MODE(2)) dut2 (.clk(clk), .clr(clr), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic after_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr   = 1'b0;
    din   = 8'h00;

    // Reset state: clr held low across both edge polarities
    after_pos();
    after_neg();
    chk("reset_m0", bus0.dataout, 8'h00);
    chk("reset_m1", bus1.dataout, 8'h00);
    chk("reset_m2", bus2.dataout, 8'h00);

    // Clear sweep
    for (int i = 0; i < 256; i++) begin
      din = 8'(i);
      after_pos();
      chk("clr_sweep_m0", bus0.dataout, 8'h00);
      chk("clr_sweep_m2p", bus2.dataout, 8'h00);
      after_neg();
      chk("clr_sweep_m1", bus1.dataout, 8'h00);
      chk("clr_sweep_m2n", bus2.dataout, 8'h00);
    end

    // Data sweep: applied while clk is low
    prev_m1 = 8'h00;
    clr = 1'b1;
    for (int i = 0; i < 256; i++) begin
      din = 8'(i);
      after_pos();
      chk("data_m0", bus0.dataout, 8'(i));
      chk("data_m2p", bus2.dataout, 8'(i));
      chk("data_m1_hold", bus1.dataout, prev_m1);
      after_neg();
      chk("data_m1", bus1.dataout, 8'(i));
      chk("data_m2n", bus2.dataout, 8'(i));
      chk("data_m0_hold", bus0.dataout, 8'(i));
      prev_m1 = 8'(i);
    end

    // Edge selectivity
    din = 8'h3C;
    after_pos();
    after_neg();
    chk("sel_m1_3c", bus1.dataout, 8'h3C);
    din = 8'hC3;
    after_pos();
    chk("sel_m1_hold", bus1.dataout, 8'h3C);
    chk("sel_m0_c3", bus0.dataout, 8'hC3);
    after_neg();
    chk("sel_m1_c3", bus1.dataout, 8'hC3);

    // Clear mid-operation
    din = 8'h55;
    after_pos();
    after_neg();
    chk("mid_m0_55", bus0.dataout, 8'h55);
    chk("mid_m1_55", bus1.dataout, 8'h55);
    chk("mid_m2_55", bus2.dataout, 8'h55);
    clr = 1'b0;
    #2;
    chk("mid_m1_noedge", bus1.dataout, 8'h55);
    chk("mid_m0_noedge", bus0.dataout, 8'h55);
    after_pos();
    chk("mid_m0_clr", bus0.dataout, 8'h00);
    chk("mid_m2_clr", bus2.dataout, 8'h00);
    chk("mid_m1_still", bus1.dataout, 8'h55);
    after_neg();
    chk("mid_m1_clr", bus1.dataout, 8'h00);
    clr = 1'b1;
    din = 8'h81;
    after_pos();
    chk("rel_m0_81", bus0.dataout, 8'h81);
    chk("rel_m2_81", bus2.dataout, 8'h81);
    chk("rel_m1_0", bus1.dataout, 8'h00);
    after_neg();
    chk("rel_m1_81", bus1.dataout, 8'h81);

    // Dual-edge alternation
    for (int k = 0; k < 4; k++) begin
      din = 8'h12;
      after_pos();
      chk("dual_12", bus2.dataout, 8'h12);
      din = 8'h34;
      after_neg();
      chk("dual_34", bus2.dataout, 8'h34);
      chk("dual_m0", bus0.dataout, 8'h12);
    end

    // Dual-edge clear on a falling edge
    din = 8'h12;
    after_pos();
    chk("dual_pre_clr", bus2.dataout, 8'h12);
    clr = 1'b0;
    after_neg();
    chk("dual_neg_clr", bus2.dataout, 8'h00);
    chk("dual_neg_clr_m1", bus1.dataout, 8'h00);
    chk("dual_neg_clr_m0", bus0.dataout, 8'h12);
    clr = 1'b1;
    din = 8'hFF;
    after_pos();
    chk("dual_ff", bus2.dataout, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
